maxmin_meas_sched: RTL
======================

// Module: maxmin_meas_sched
// PURPOSE
//  Round-robin scheduler sharing one max/min-averaging engine among NCH channels.
//  Latches per-channel measurement requests, muxes the granted channel's data into the engine,
//  pulses the engine start, waits for its ready pulse, returns max/min averages and amplitude.
//  Sits between the demodulator channels and the single max/min engine instance.
// PARAMETERS
//  NCH          4        number of requesting channels (2..8)
//  INPUT_WIDTH  13       signed sample / result width
//  TO_WIDTH     24       timeout counter width
//  TIMEOUT_CYC  24'd4000 max cycles in WAIT before abort (must exceed engine run time)
// PORTS
//  clk          in   1                 system clock
//  rst_n        in   1                 asynchronous reset, active-low
//  req          in   NCH               per-channel request pulse (1 cycle, bit i = channel i)
//  ch_dat       in   NCH*INPUT_WIDTH   channel samples, ch i at [i*IW +: IW], signed
//  eng_start    out  1                 engine start pulse (1 cycle)
//  eng_dat      out  INPUT_WIDTH       muxed sample of granted channel
//  eng_max_avg  in   INPUT_WIDTH       engine max average, signed
//  eng_min_avg  in   INPUT_WIDTH       engine min average, signed
//  eng_dready   in   1                 engine result pulse (1 cycle)
//  grant        out  NCH               one-hot granted channel, 0 when idle
//  busy         out  1                 high in any state but IDLE
//  pending      out  NCH               latched outstanding requests
//  res_valid    out  1                 result pulse (1 cycle)
//  res_ch       out  $clog2(NCH)       channel of result
//  res_max      out  INPUT_WIDTH       captured max average
//  res_min      out  INPUT_WIDTH       captured min average
//  res_amp      out  INPUT_WIDTH+1     res_max - res_min, signed, full width (no overflow)
//  res_err      out  1                 qualifies res_valid: 1 = timeout, results forced 0
// BEHAVIOUR
//  Reset: all outputs 0, pending 0, state IDLE, rr pointer -> channel 0 has top priority.
//  pending[i] set on req[i]; cleared when res_valid issued for i. Set wins over clear same cycle.
//  States: IDLE -> ARB when |pending; ARB -> START (1 cyc) -> WAIT -> DONE (1 cyc) -> IDLE.
//  ARB: pick first pending at/after rr pointer (wraps NCH-1 -> 0); register grant; pointer <= sel+1.
//  START: eng_start=1 one cycle. eng_dat = ch_dat[sel] combinationally from grant, valid
//   from START through DONE; 0 when grant==0.
//  WAIT: count cycles from 0; eng_dready -> capture max/min, go DONE;
//   count == TIMEOUT_CYC-1 without dready -> DONE with res_err=1, results 0.
//  DONE: res_valid=1, res_ch=sel, grant cleared next cycle; outputs res_* hold until next DONE.
//  Latency: req in IDLE to eng_start = 3 clk (latch, ARB, START); dready to res_valid = 1 clk.
//  eng_dready outside WAIT ignored (stale pulse); never produces res_valid.
//  dready and timeout in same cycle: dready wins, res_err=0.
//  req for channel being served: re-pending, served again after rr rotation.
//  Async reset mid-WAIT: abort immediately, no res_valid, pending lost.
//  res_amp computed with sign-extended operands, registered in DONE alongside res_max/min.
// STRUCTURE
//  Package maxmin_sched_pkg: state encoding (one-hot, 5 states), CH_W=$clog2(NCH) function,
//   TIMEOUT default constant.
//  One sub-module: rr_arbiter (pending, pointer -> one-hot grant + index, combinational).
//  Top: FSM, timeout counter, data mux, result registers.
// TESTING
//  req=0001 in IDLE -> eng_start at cycle+3, grant=0001; dready with max=100,min=-20 ->
//   next cycle res_valid, res_ch=0, res_max=100, res_min=-20, res_amp=120, res_err=0.
//  req=1011 same cycle -> served order ch0,ch1,ch3; then req=0001+0010 -> ch1 before ch0
//   only if pointer past 0 (after ch3 pointer wraps to 0: order ch0,ch1).
//  no dready, TIMEOUT_CYC=16 -> res_valid with res_err=1, res_max=res_min=res_amp=0, 16 cyc in WAIT.
//  eng_dready pulse in IDLE -> no res_valid, state unchanged; in WAIT same cycle as timeout -> res_err=0.
//  req[2] during ch2 WAIT -> ch2 result, pending[2] stays 1, second ch2 measurement follows.
//  rst_n low during WAIT -> grant=0, busy=0, pending=0 same cycle; late dready ignored.
//  max=4095, min=-4096 (IW=13) -> res_amp=8191, no wrap.

Source files
------------

// File: rtl/maxmin_sched_pkg.sv
// Shared types and constants for the max/min measurement scheduler.
// State encoding is one-hot so illegal states are easy to spot.
package maxmin_sched_pkg;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ARB   = 5'b00010,
        ST_START = 5'b00100,
        ST_WAIT  = 5'b01000,
        ST_DONE  = 5'b10000
    } state_t;

    localparam logic [23:0] TIMEOUT_DEFAULT = 24'd4000;

    function automatic int ch_w(input int nch);
        if (nch <= 1) begin
            return 1;
        end else begin
            return $clog2(nch);
        end
    endfunction

endpackage

// File: rtl/maxmin_meas_sched_rr_arbiter.sv
// Combinational round-robin pick: first pending channel at or after ptr,
// wrapping from NCH-1 back to 0.
module rr_arbiter #(
    parameter int NCH  = 4,
    parameter int CH_W = 2
) (
    input  logic [NCH-1:0]  pending,
    input  logic [CH_W-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [CH_W-1:0] idx,
    output logic            any
);

    logic [2*NCH-1:0] dbl_s;
    int               off_s;
    int               sum_s;

    // Rotate the request vector so ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        dbl_s = {pending, pending} >> ptr;
        off_s = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            off_s = dbl_s[k] ? k : off_s;
        end
        sum_s = int'(ptr) + off_s;
        sum_s = (sum_s >= NCH) ? (sum_s - NCH) : sum_s;
        any   = |pending;
        idx   = CH_W'(sum_s);
        gnt   = any ? (NCH'(1) << idx) : '0;
    end

endmodule

// File: rtl/maxmin_meas_sched.sv
// Round-robin scheduler sharing one max/min-averaging engine among NCH channels:
// latches requests, feeds the granted channel to the engine, returns its results.
module maxmin_meas_sched
    import maxmin_sched_pkg::*;
#(
    parameter int                  NCH         = 4,
    parameter int                  INPUT_WIDTH = 13,
    parameter int                  TO_WIDTH    = 24,
    parameter logic [TO_WIDTH-1:0] TIMEOUT_CYC = TO_WIDTH'(TIMEOUT_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NCH-1:0]             req,
    input  logic [NCH*INPUT_WIDTH-1:0] ch_dat,
    output logic                       eng_start,
    output logic [INPUT_WIDTH-1:0]     eng_dat,
    input  logic [INPUT_WIDTH-1:0]     eng_max_avg,
    input  logic [INPUT_WIDTH-1:0]     eng_min_avg,
    input  logic                       eng_dready,
    output logic [NCH-1:0]             grant,
    output logic                       busy,
    output logic [NCH-1:0]             pending,
    output logic                       res_valid,
    output logic [$clog2(NCH)-1:0]     res_ch,
    output logic [INPUT_WIDTH-1:0]     res_max,
    output logic [INPUT_WIDTH-1:0]     res_min,
    output logic [INPUT_WIDTH:0]       res_amp,
    output logic                       res_err
);

    localparam int CH_W = ch_w(NCH);
    localparam int IW   = INPUT_WIDTH;

    state_t              state_r, state_s;
    logic [NCH-1:0]      grant_r, pending_r, rereq_r;
    logic [CH_W-1:0]     sel_r, ptr_r;
    logic [TO_WIDTH-1:0] cnt_r;
    logic                eng_start_r, busy_r, res_valid_r, res_err_r;
    logic [CH_W-1:0]     res_ch_r;
    logic [IW-1:0]       res_max_r, res_min_r, eng_dat_s;
    logic [IW:0]         res_amp_r, amp_s;

    logic [NCH-1:0]      arb_gnt_s, clr_s, serve_mask_s;
    logic [CH_W-1:0]     arb_idx_s;
    logic                arb_any_s, dready_hit_s, timeout_s, finish_s, track_s;

    rr_arbiter #(.NCH(NCH), .CH_W(CH_W)) u_arb (
        .pending (pending_r),
        .ptr     (ptr_r),
        .gnt     (arb_gnt_s),
        .idx     (arb_idx_s),
        .any     (arb_any_s)
    );

    // A dready in the timeout cycle still counts as a good result.
    assign dready_hit_s = (state_r == ST_WAIT) && eng_dready;
    assign timeout_s    = (state_r == ST_WAIT) && !eng_dready &&
                          (cnt_r == (TIMEOUT_CYC - TO_WIDTH'(1)));
    assign finish_s     = dready_hit_s || timeout_s;
    assign clr_s        = finish_s ? grant_r : '0;
    assign serve_mask_s = (state_r == ST_ARB) ? arb_gnt_s : grant_r;
    assign track_s      = (state_r == ST_ARB) || (state_r == ST_START) || (state_r == ST_WAIT);
    assign amp_s        = {eng_max_avg[IW-1], eng_max_avg} - {eng_min_avg[IW-1], eng_min_avg};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = arb_any_s ? ST_ARB : ST_IDLE;
            ST_ARB:   state_s = ST_START;
            ST_START: state_s = ST_WAIT;
            ST_WAIT:  state_s = finish_s ? ST_DONE : ST_WAIT;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Grant, selected index and rotating priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r <= '0;
            sel_r   <= '0;
            ptr_r   <= '0;
        end else if (state_r == ST_ARB) begin
            grant_r <= arb_gnt_s;
            sel_r   <= arb_idx_s;
            ptr_r   <= (arb_idx_s == CH_W'(NCH - 1)) ? '0 : (arb_idx_s + CH_W'(1));
        end else if (state_r == ST_DONE) begin
            grant_r <= '0;
        end else begin
            grant_r <= grant_r;
        end
    end

    // Engine start pulse, busy flag and WAIT cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_start_r <= 1'b0;
            busy_r      <= 1'b0;
            cnt_r       <= '0;
        end else begin
            eng_start_r <= (state_r == ST_ARB);
            busy_r      <= (state_s != ST_IDLE);
            cnt_r       <= (state_r == ST_WAIT) ? (cnt_r + TO_WIDTH'(1)) : '0;
        end
    end

    // Request latch; a re-request of the channel in service survives its own clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= '0;
            rereq_r   <= '0;
        end else begin
            pending_r <= (pending_r & ~clr_s) | req | (rereq_r & clr_s);
            if (finish_s) begin
                rereq_r <= '0;
            end else if (track_s) begin
                rereq_r <= rereq_r | (req & serve_mask_s);
            end else begin
                rereq_r <= rereq_r;
            end
        end
    end

    // Result capture; values hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_err_r   <= 1'b0;
            res_ch_r    <= '0;
            res_max_r   <= '0;
            res_min_r   <= '0;
            res_amp_r   <= '0;
        end else if (finish_s) begin
            res_valid_r <= 1'b1;
            res_err_r   <= timeout_s;
            res_ch_r    <= sel_r;
            res_max_r   <= dready_hit_s ? eng_max_avg : '0;
            res_min_r   <= dready_hit_s ? eng_min_avg : '0;
            res_amp_r   <= dready_hit_s ? amp_s : '0;
        end else begin
            res_valid_r <= 1'b0;
        end
    end

    // Sample mux driven straight from the registered grant.
    always_comb begin
        eng_dat_s = '0;
        for (int i = 0; i < NCH; i++) begin
            eng_dat_s = grant_r[i] ? ch_dat[i*IW +: IW] : eng_dat_s;
        end
    end

    assign eng_start = eng_start_r;
    assign eng_dat   = eng_dat_s;
    assign grant     = grant_r;
    assign busy      = busy_r;
    assign pending   = pending_r;
    assign res_valid = res_valid_r;
    assign res_ch    = res_ch_r;
    assign res_max   = res_max_r;
    assign res_min   = res_min_r;
    assign res_amp   = res_amp_r;
    assign res_err   = res_err_r;

endmodule
